// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the ALU operation scheduler.
package alu_sched_pkg;

   localparam int OPC_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } sched_state_e;

   typedef enum logic {
      LAT_CLASS_ALU = 1'b0,
      LAT_CLASS_MUL = 1'b1
   } lat_class_e;

   // Multiply class: group 00 with sub-op 010, or any other group with sub-op 011.
   // Written with masks so every opcode bit takes part in the expression.
   function automatic logic is_mul_opc(input logic [OPC_W-1:0] opc);
      logic grp0_mul;
      logic grpn_mul;
      grp0_mul = ((opc & 8'hC7) == 8'h02);
      grpn_mul = ((opc & 8'hC0) != 8'h00) && ((opc & 8'h07) == 8'h03);
      return grp0_mul || grpn_mul;
   endfunction

   function automatic lat_class_e opc_class(input logic [OPC_W-1:0] opc);
      return is_mul_opc(opc) ? LAT_CLASS_MUL : LAT_CLASS_ALU;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping)
// whose request is set and whose lock_mask bit allows it. Grant is one-hot.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   input  logic [NREQ-1:0]  lock_mask,
   output logic [NREQ-1:0]  gnt
);

   logic found;

   // Walk the requesters in priority order starting at ptr; first eligible wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!found && (j == (int'(ptr) + k) % NREQ) && req[j] && lock_mask[j]) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between NREQ requesters. Round-robin arbitration with an
// optional per-requester lock for accumulator-style back-to-back sequences.
// Operands are registered onto the ALU, held for the opcode's latency class,
// and the captured result is returned tagged with the winner's index.
//
// state | meaning
// IDLE  | waiting for an enabled, eligible request; req_ready is combinational here
// WAIT  | ALU inputs held; counter runs down, result captured when it reaches 1
// RESP  | resp_valid/resp_id/resp_z presented for one cycle
module alu_op_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int ALU_LAT = 1,
   parameter int MUL_LAT = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_lock,
   input  logic [NREQ*OPC_W-1:0] req_opc,
   input  logic [NREQ*OPC_W-1:0] req_a,
   input  logic [NREQ*OPC_W-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  resp_valid,
   output logic [1:0]            resp_id,
   output logic [OPC_W-1:0]      resp_z,
   output logic [OPC_W-1:0]      alu_opc,
   output logic [OPC_W-1:0]      alu_a,
   output logic [OPC_W-1:0]      alu_b,
   input  logic [OPC_W-1:0]      alu_z,
   output logic                  busy
);

   localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   sched_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic              lock_act_q, lock_act_d;
   logic [1:0]        lock_id_q, lock_id_d;
   logic [1:0]        cur_id_q, cur_id_d;
   logic [OPC_W-1:0]  alu_opc_q, alu_opc_d;
   logic [OPC_W-1:0]  alu_a_q, alu_a_d;
   logic [OPC_W-1:0]  alu_b_q, alu_b_d;
   logic              resp_valid_q, resp_valid_d;
   logic [1:0]        resp_id_q, resp_id_d;
   logic [OPC_W-1:0]  resp_z_q, resp_z_d;
   logic              busy_q, busy_d;

   logic [NREQ-1:0]   lock_mask;
   logic [NREQ-1:0]   gnt;
   logic              accept;
   logic [1:0]        win_id;
   logic [PTR_W-1:0]  win_nxt;
   logic [OPC_W-1:0]  sel_opc;
   logic [OPC_W-1:0]  sel_a;
   logic [OPC_W-1:0]  sel_b;
   logic              sel_lock;

   // While a lock is held only the owner is eligible, even when it is idle.
   always_comb begin
      lock_mask = '1;
      if (lock_act_q) begin
         for (int i = 0; i < NREQ; i++) begin
            lock_mask[i] = (2'(i) == lock_id_q);
         end
      end
   end

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .lock_mask (lock_mask),
      .gnt       (gnt)
   );

   // Acceptance only from IDLE with enable; reset keeps the handshake quiet.
   assign req_ready = (state_q == ST_IDLE && enable && !reset) ? gnt : '0;
   assign accept    = |req_ready;

   // Mux the winning requester's fields and derive the next pointer.
   always_comb begin
      win_id   = '0;
      win_nxt  = '0;
      sel_opc  = '0;
      sel_a    = '0;
      sel_b    = '0;
      sel_lock = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            win_id   = 2'(i);
            win_nxt  = PTR_W'((i + 1) % NREQ);
            sel_opc  = req_opc[i*OPC_W +: OPC_W];
            sel_a    = req_a[i*OPC_W +: OPC_W];
            sel_b    = req_b[i*OPC_W +: OPC_W];
            sel_lock = req_lock[i];
         end
      end
   end

   // Next-state and registered-output logic for the scheduler FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      lock_act_d   = lock_act_q;
      lock_id_d    = lock_id_q;
      cur_id_d     = cur_id_q;
      alu_opc_d    = alu_opc_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      resp_valid_d = 1'b0;
      resp_id_d    = resp_id_q;
      resp_z_d     = resp_z_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               alu_opc_d  = sel_opc;
               alu_a_d    = sel_a;
               alu_b_d    = sel_b;
               cnt_d      = (opc_class(sel_opc) == LAT_CLASS_MUL) ? MUL_CNT : ALU_CNT;
               cur_id_d   = win_id;
               ptr_d      = win_nxt;
               lock_act_d = sel_lock;
               lock_id_d  = win_id;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_ONE) begin
               resp_z_d     = alu_z;
               resp_id_d    = cur_id_q;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset aborts any in-flight transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         ptr_q        <= '0;
         lock_act_q   <= 1'b0;
         lock_id_q    <= '0;
         cur_id_q     <= '0;
         alu_opc_q    <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_z_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
         lock_act_q   <= lock_act_d;
         lock_id_q    <= lock_id_d;
         cur_id_q     <= cur_id_d;
         alu_opc_q    <= alu_opc_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_z_q     <= resp_z_d;
         busy_q       <= busy_d;
      end
   end

   assign alu_opc    = alu_opc_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_z     = resp_z_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus random traffic, checked
// every cycle against a transaction-timeline model of the scheduler.
module tb_alu_op_scheduler;

   localparam int NREQ    = 2;
   localparam int ALU_LAT = 1;
   localparam int MUL_LAT = 8;

   logic                clock = 1'b0;
   logic                reset;
   logic                enable;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_lock;
   logic [NREQ*8-1:0]   req_opc;
   logic [NREQ*8-1:0]   req_a;
   logic [NREQ*8-1:0]   req_b;
   logic [NREQ-1:0]     req_ready;
   logic                resp_valid;
   logic [1:0]          resp_id;
   logic [7:0]          resp_z;
   logic [7:0]          alu_opc;
   logic [7:0]          alu_a;
   logic [7:0]          alu_b;
   logic [7:0]          alu_z;
   logic                busy;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   alu_op_scheduler #(
      .NREQ    (NREQ),
      .ALU_LAT (ALU_LAT),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .req_valid  (req_valid),
      .req_lock   (req_lock),
      .req_opc    (req_opc),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_z     (resp_z),
      .alu_opc    (alu_opc),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_z      (alu_z),
      .busy       (busy)
   );

   function automatic bit tb_is_mul(input logic [7:0] opc);
      if (opc[7:6] == 2'b00) return opc[2:0] == 3'd2;
      return opc[2:0] == 3'd3;
   endfunction

   // Stand-in ALU: combinational, multiply for the multiply class.
   function automatic logic [7:0] tb_alu(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
      if (tb_is_mul(opc)) return a * b;
      case (opc[2:0])
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a << 1;
         default: return b;
      endcase
   endfunction

   assign alu_z = tb_alu(alu_opc, alu_a, alu_b);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Timeline model: one transaction at a time, described by its acceptance cycle.
   int         cyc = 0;
   int         m_last, m_lock, m_acc, m_resp, m_free, m_lat;
   logic [1:0] m_id;
   logic [7:0] m_z, m_rz, m_opc, m_a, m_b;
   int         last_grant;
   logic       saw_resp;

   task automatic model_reset();
      m_last = NREQ - 1;
      m_lock = -1;
      m_acc  = -1;
      m_resp = -1;
      m_free = cyc;
      m_lat  = 0;
      m_id   = '0;
      m_z    = '0;
      m_rz   = '0;
      m_opc  = '0;
      m_a    = '0;
      m_b    = '0;
   endtask

   task automatic set_req(input int i, input logic v, input logic l,
                          input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
      req_valid[i]      = v;
      req_lock[i]       = l;
      req_opc[i*8 +: 8] = o;
      req_a[i*8 +: 8]   = x;
      req_b[i*8 +: 8]   = y;
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_ready"}, req_ready, 0);
      chk({pfx, "_resp_valid"}, resp_valid, 0);
      chk({pfx, "_resp_id"}, resp_id, 0);
      chk({pfx, "_resp_z"}, resp_z, 0);
      chk({pfx, "_alu_opc"}, alu_opc, 0);
      chk({pfx, "_alu_a"}, alu_a, 0);
      chk({pfx, "_alu_b"}, alu_b, 0);
      chk({pfx, "_busy"}, busy, 0);
   endtask

   // One clock period: inputs already driven; check, update model, advance.
   task automatic run_cycle();
      logic [NREQ-1:0] exp_rdy;
      int w;
      #1;
      exp_rdy = '0;
      w = -1;
      if (enable && cyc >= m_free) begin
         for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (w < 0 && req_valid[j] && (m_lock < 0 || m_lock == j)) w = j;
         end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      if (cyc == m_resp) m_rz = m_z;
      saw_resp = resp_valid;

      chk("req_ready", req_ready, exp_rdy);
      chk("resp_valid", resp_valid, cyc == m_resp);
      if (cyc == m_resp) chk("resp_id", resp_id, m_id);
      chk("resp_z", resp_z, m_rz);
      chk("busy", busy, (m_acc >= 0 && cyc > m_acc && cyc < m_free));
      if (m_acc >= 0 && cyc > m_acc && cyc <= m_acc + m_lat) begin
         chk("alu_opc", alu_opc, m_opc);
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
      end

      last_grant = w;
      if (w >= 0) begin
         m_acc  = cyc;
         m_id   = 2'(w);
         m_opc  = req_opc[w*8 +: 8];
         m_a    = req_a[w*8 +: 8];
         m_b    = req_b[w*8 +: 8];
         m_lat  = tb_is_mul(m_opc) ? MUL_LAT : ALU_LAT;
         m_z    = tb_alu(m_opc, m_a, m_b);
         m_resp = cyc + 1 + m_lat;
         m_free = cyc + 2 + m_lat;
         m_last = w;
         m_lock = req_lock[w] ? w : -1;
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (cyc < m_free && g < 40) begin
         run_cycle();
         g++;
      end
      chk("drain_done", cyc >= m_free, 1'b1);
   endtask

   initial begin
      int ng, nr;
      int tp4_exp[5];
      tp4_exp = '{0, 0, 0, 0, 1};

      reset     = 1'b1;
      enable    = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_opc   = '0;
      req_a     = '0;
      req_b     = '0;
      last_grant = -1;
      saw_resp   = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("rst");
      reset = 1'b0;
      model_reset();

      // Single-cycle add from requester 0.
      set_req(0, 1'b1, 1'b0, 8'h20, 8'd3, 8'd5);
      run_cycle();
      chk("tp1_grant", last_grant, 0);
      set_req(0, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0);
      run_cycle();
      run_cycle();
      chk("tp1_resp_seen", saw_resp, 1'b1);
      chk("tp1_z", resp_z, 8'd8);
      chk("tp1_id", resp_id, 2'd0);
      drain();

      // Multiply from requester 1.
      set_req(1, 1'b1, 1'b0, 8'h22, 8'd3, 8'd5);
      run_cycle();
      chk("tp2_grant", last_grant, 1);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0);
      repeat (8) run_cycle();
      run_cycle();
      chk("tp2_resp_seen", saw_resp, 1'b1);
      chk("tp2_z", resp_z, 8'd15);
      drain();

      // Both requesters continuously valid: grants alternate.
      ng = 0;
      for (int g = 0; g < 100 && ng < 8; g++) begin
         set_req(0, 1'b1, 1'b0, 8'h20, 8'($urandom), 8'($urandom));
         set_req(1, 1'b1, 1'b0, 8'h20, 8'($urandom), 8'($urandom));
         run_cycle();
         if (last_grant >= 0) begin
            chk("tp3_order", last_grant, ng % 2);
            ng++;
         end
      end
      chk("tp3_count", ng, 8);
      req_valid = '0;
      drain();

      // Lock held by requester 0 for three requests, released on the fourth.
      ng = 0;
      nr = 0;
      for (int g = 0; g < 100 && ng < 5; g++) begin
         set_req(0, nr < 4, nr < 3, 8'h20, 8'($urandom), 8'($urandom));
         set_req(1, 1'b1, 1'b0, 8'h20, 8'($urandom), 8'($urandom));
         run_cycle();
         if (last_grant >= 0) begin
            chk("tp4_order", last_grant, tp4_exp[ng]);
            if (last_grant == 0) nr++;
            ng++;
         end
      end
      chk("tp4_count", ng, 5);
      req_valid = '0;
      req_lock  = '0;
      drain();

      // Enable dropped during a multiply: response still issued, no new grant.
      set_req(0, 1'b1, 1'b0, 8'h22, 8'd7, 8'd9);
      run_cycle();
      chk("tp5_grant", last_grant, 0);
      enable = 1'b0;
      set_req(0, 1'b1, 1'b0, 8'h20, 8'd1, 8'd2);
      set_req(1, 1'b1, 1'b0, 8'h20, 8'd4, 8'd4);
      ng = 0;
      nr = 0;
      repeat (14) begin
         run_cycle();
         if (last_grant >= 0) ng++;
         if (saw_resp) nr++;
      end
      chk("tp5_no_grant", ng, 0);
      chk("tp5_resp_count", nr, 1);
      chk("tp5_z", resp_z, 8'd63);
      enable = 1'b1;
      run_cycle();
      chk("tp5_grant_after", last_grant, 1);
      req_valid = '0;
      drain();

      // Reset in the middle of a multiply.
      set_req(1, 1'b1, 1'b0, 8'h22, 8'd11, 8'd13);
      run_cycle();
      chk("tp6_grant", last_grant, 1);
      req_valid = '0;
      repeat (3) run_cycle();
      reset = 1'b1;
      #2;
      check_all_zero("rst_mid");
      @(posedge clock);
      #1;
      reset = 1'b0;
      cyc++;
      model_reset();
      set_req(0, 1'b1, 1'b0, 8'h20, 8'd2, 8'd2);
      set_req(1, 1'b1, 1'b0, 8'h20, 8'd6, 8'd6);
      run_cycle();
      chk("tp6_grant_after_reset", last_grant, 0);
      req_valid = '0;
      drain();

      // Random traffic with locks, withdrawals and enable gaps.
      for (int n = 0; n < 3000; n++) begin
         enable = ($urandom_range(7) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(3) == 0)
                  set_req(i, 1'b1, ($urandom_range(4) == 0), 8'($urandom), 8'($urandom), 8'($urandom));
            end else if ($urandom_range(15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         run_cycle();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

endmodule
